shift_issue: RTL and testbench

Issue stage directly upstream of the `shift` block. It accepts decoded RISC-V OP/OP-IMM instructions with their register operands over a valid/ready handshake. It extracts the shift amount and maps funct3/funct7 onto the 4-bit shift operation code. It presents registered `A`, `B` and `operation` to the shifter through a 2-entry skid buffer, giving full throughput with registered outputs.

---
 rtl/shift_issue.sv | 165 ++++++++++++++++
 tb/tb_shift_issue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue.sv
// -----------------------------------------------------------------------------
// shift_issue
//
// Issue stage in front of the shifter. Accepts decoded RISC-V OP / OP-IMM
// instructions over a valid/ready handshake and extracts the shift amount.
// It maps funct3/funct7 onto the shifter's 4-bit operation code. Each decoded
// entry goes out through a 2-entry skid buffer (main + skid), so the outputs
// are registered and the stage still sustains one entry per cycle.
// Non-shift instructions are consumed silently and counted in drop_count,
// which saturates at 16'hFFFF.
//
// Optional feature macro: SHIFT_ISSUE_ILLEGAL_EN
//   defined   : shift opcodes with a malformed funct7 are emitted with
//               operation=4'b0000 and out_illegal=1
//   undefined : funct7 is ignored except bit 5 on funct3 101; out_illegal=0
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  upstream handshake (in_ready is a flop output)
//   instr           raw instruction word
//   rs1_data        shift source operand
//   rs2_data        shift amount source for OP (low 5 bits only)
//   out_valid/ready downstream handshake
//   A, B, operation shifter operands: source, zero-extended amount, op code
//   out_illegal     emitted entry is a malformed shift
//   drop_count      saturating count of accepted non-shift instructions
// -----------------------------------------------------------------------------
module shift_issue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [3:0]  operation,
   output logic        out_illegal,
   output logic [15:0] drop_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [3:0] OP_NONE    = 4'b0000;
   localparam logic [3:0] OP_SLL     = 4'b0010;
   localparam logic [3:0] OP_SRL     = 4'b0011;
   localparam logic [3:0] OP_SRA     = 4'b0100;

   typedef struct packed {
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [3:0]  op;
      logic        ill;
   } entry_t;

   entry_t      main_q, main_d, skid_q, skid_d, new_entry;
   logic        main_valid_q, main_valid_d;
   logic        skid_valid_q, skid_valid_d;
   logic        in_ready_q;
   logic [15:0] drop_q, drop_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_shift, accept, push, main_free;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register-number fields are resolved upstream; they are not needed here.
   logic unused_bits;
`ifdef SHIFT_ISSUE_ILLEGAL_EN
   assign unused_bits = ^{instr[19:15], instr[11:7], rs2_data[31:5]};
`else
   assign unused_bits = ^{instr[19:15], instr[11:7], rs2_data[31:5],
                          funct7[6], funct7[4:0]};
`endif

   // ---------------------------------------------------------------- decode
   always_comb begin
      is_shift  = ((opcode == OPC_OP) || (opcode == OPC_OP_IMM)) &&
                  ((funct3 == 3'b001) || (funct3 == 3'b101));
      new_entry       = '0;
      new_entry.a     = rs1_data;
      new_entry.shamt = (opcode == OPC_OP) ? rs2_data[4:0] : instr[24:20];
      if (funct3 == 3'b001)
         new_entry.op = OP_SLL;
      else if (funct7[5])
         new_entry.op = OP_SRA;
      else
         new_entry.op = OP_SRL;
`ifdef SHIFT_ISSUE_ILLEGAL_EN
      if (((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
          ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
           (funct7 != 7'b0100000))) begin
         new_entry.op  = OP_NONE;
         new_entry.ill = 1'b1;
      end
`endif
   end

   assign accept    = in_valid && in_ready_q;
   assign push      = accept && is_shift;
   // Main can take a new entry when it is empty or being consumed this cycle.
   assign main_free = !main_valid_q || out_ready;

   // ----------------------------------------------------------- next state
   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      drop_d       = drop_q;

      if (main_free) begin
         // A full skid implies in_ready was low, so push cannot collide here.
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = push;
            if (push)
               main_d = new_entry;
         end
      end else if (push) begin
         skid_d       = new_entry;
         skid_valid_d = 1'b1;
      end

      if (accept && !is_shift && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         drop_q       <= '0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= !skid_valid_d;
         drop_q       <= drop_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = main_valid_q;
   assign A           = main_q.a;
   assign B           = {27'b0, main_q.shamt};
   assign operation   = main_q.op;
   assign out_illegal = main_q.ill;   // constant 0 unless the macro is defined
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] A, B;
   logic [3:0]  operation;
   logic        out_illegal;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

   shift_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .A(A), .B(B), .operation(operation), .out_illegal(out_illegal),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   typedef struct {
      bit          shift;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        ill;
   } ent_t;

   ent_t ref_q[$];        // entries held by the stage, oldest first
   int   ref_drops = 0;

   function automatic ent_t ref_decode(input logic [31:0] ins, r1, r2);
      ent_t e;
      int op7, f3, f7;
      op7 = int'(ins[6:0]);
      f3  = int'(ins[14:12]);
      f7  = int'(ins[31:25]);
      e.shift = (op7 == 'h33 || op7 == 'h13) && (f3 == 1 || f3 == 5);
      e.a     = r1;
      e.b     = (op7 == 'h33) ? (r2 % 32) : ((ins >> 20) % 32);
      e.op    = (f3 == 1) ? 4'd2 : (((f7 & 'h20) != 0) ? 4'd4 : 4'd3);
      e.ill   = 1'b0;
`ifdef SHIFT_ISSUE_ILLEGAL_EN
      if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20)) begin
         e.op  = 4'd0;
         e.ill = 1'b1;
      end
`endif
      return e;
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] sh,
                                      input logic [2:0] f3, input logic [6:0] opc);
      return {f7, sh, 5'd3, f3, 5'd1, opc};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One clock cycle: compare DUT with the model, drive new inputs, then
   // advance the model by what the coming rising edge will do.
   task automatic cycle(input logic v, input logic [31:0] ins, r1, r2, input logic ordy);
      ent_t e;
      bit   acc, pop;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(ref_q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(ref_q.size() < 2));
      check("drop_count", 32'(drop_count), 32'(ref_drops));
      if (ref_q.size() > 0) begin
         check("A", A, ref_q[0].a);
         check("B", B, ref_q[0].b);
         check("operation", 32'(operation), 32'(ref_q[0].op));
         check("out_illegal", 32'(out_illegal), 32'(ref_q[0].ill));
      end
      in_valid  = v;
      instr     = ins;
      rs1_data  = r1;
      rs2_data  = r2;
      out_ready = ordy;
      acc = v && (ref_q.size() < 2);
      pop = (ref_q.size() > 0) && ordy;
      e   = ref_decode(ins, r1, r2);
      if (pop) void'(ref_q.pop_front());
      if (acc) begin
         if (e.shift) ref_q.push_back(e);
         else if (ref_drops < 65535) ref_drops++;
      end
      $display("cyc v=%0d instr=%h rs1=%h rs2=%h ordy=%0d acc=%0d pop=%0d held=%0d",
               v, ins, r1, r2, ordy, acc, pop, ref_q.size());
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] slli4, srai_op, add_i, sll_op, bad_slli, rnd_i;
   logic [6:0]  opc_r, f7_r;

   initial begin
      slli4    = mk(7'h00, 5'd4, 3'b001, 7'h13);
      srai_op  = mk(7'h20, 5'd2, 3'b101, 7'h33);
      add_i    = mk(7'h00, 5'd2, 3'b000, 7'h33);
      sll_op   = mk(7'h00, 5'd2, 3'b001, 7'h33);
      bad_slli = mk(7'h01, 5'd7, 3'b001, 7'h13);

      // Reset state
      #12;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst A", A, 32'd0);
      check("rst B", B, 32'd0);
      check("rst operation", 32'(operation), 32'd0);
      check("rst out_illegal", 32'(out_illegal), 32'd0);
      check("rst drop_count", 32'(drop_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // SLLI shamt=4
      cycle(1, slli4, 32'h1, 32'h0, 1);
      after_edge();
      check("slli out_valid", 32'(out_valid), 32'd1);
      check("slli A", A, 32'h1);
      check("slli B", B, 32'h4);
      check("slli operation", 32'(operation), 32'h2);

      // OP SRA, only rs2_data[4:0] reaches B
      cycle(1, srai_op, 32'h8000_0000, 32'hFFFF_FFE3, 1);
      after_edge();
      check("sra B", B, 32'h3);
      check("sra operation", 32'(operation), 32'h4);
      cycle(0, 0, 0, 0, 1);

      // Backpressure: three back-to-back shifts
      cycle(1, sll_op, 32'h1, 32'h1, 0);
      cycle(1, sll_op, 32'h2, 32'h1, 0);
      after_edge();
      check("bp in_ready", 32'(in_ready), 32'd0);
      cycle(1, sll_op, 32'h3, 32'h1, 0);
      cycle(1, sll_op, 32'h3, 32'h1, 1);
      after_edge();
      check("release in_ready", 32'(in_ready), 32'd1);
      check("release A", A, 32'h2);
      cycle(1, sll_op, 32'h3, 32'h1, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);

      // ADD is dropped
      cycle(1, add_i, 32'h5, 32'h6, 1);
      after_edge();
      check("add out_valid", 32'(out_valid), 32'd0);
      check("add drop_count", 32'(drop_count), 32'd1);

      // Malformed SLLI
      cycle(1, bad_slli, 32'h9, 32'h0, 1);
      after_edge();
`ifdef SHIFT_ISSUE_ILLEGAL_EN
      check("bad operation", 32'(operation), 32'h0);
      check("bad out_illegal", 32'(out_illegal), 32'd1);
`else
      check("bad operation", 32'(operation), 32'h2);
      check("bad out_illegal", 32'(out_illegal), 32'd0);
`endif
      check("bad B", B, 32'h7);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0:       opc_r = 7'h33;
            1:       opc_r = 7'h13;
            2:       opc_r = 7'h13;
            default: opc_r = 7'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0:       f7_r = 7'h00;
            1:       f7_r = 7'h20;
            default: f7_r = 7'($urandom);
         endcase
         rnd_i = mk(f7_r, 5'($urandom), 3'($urandom), opc_r);
         cycle(1'($urandom_range(0, 3) != 0), rnd_i, $urandom, $urandom,
               1'($urandom_range(0, 2) != 0));
      end

      // Asynchronous reset with both entries full
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(1, sll_op, 32'h11, 32'h1, 0);
      cycle(1, sll_op, 32'h22, 32'h1, 0);
      @(posedge clk);
      #2;
      check("full before rst in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst in_ready", 32'(in_ready), 32'd1);
      check("async rst A", A, 32'd0);
      check("async rst operation", 32'(operation), 32'd0);
      in_valid = 1'b0;
      ref_q.delete();
      ref_drops = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 0, 0, 1);
      cycle(1, slli4, 32'h44, 32'h0, 1);
      cycle(0, 0, 0, 0, 1);

      // drop_count saturation
      for (int i = 0; i < 65540; i++)
         cycle(1, add_i, 32'h0, 32'h0, 1);
      cycle(0, 0, 0, 0, 1);
      check("drop saturate", 32'(drop_count), 32'h0000_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
